// File: rtl/rr_mux8_arbiter_pkg.sv
// rr_mux8_arbiter_pkg: shared state encodings and sizes for the round-robin mux arbiter
package rr_mux8_arbiter_pkg;
    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_BUSY = 1'b1
    } state_t;
    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;
endpackage

// File: rtl/mux8by1.sv
// mux8by1: 8:1 lane selector over a flat bus of W-bit lanes
module mux8by1 #(
    parameter int W = 4
) (
    input  logic [8*W-1:0] d,
    input  logic [2:0]     op,
    output logic [W-1:0]   y
);
    assign y = d[op*W +: W];
endmodule

// File: rtl/rr_mux8_arbiter_pick8.sv
// rr_pick8: rotate-and-priority-encode picker; first set bit of elig starting at ptr
module rr_pick8
    import rr_mux8_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] elig,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   w
);
    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   idx;
    always_comb begin
        rot = NUM_REQ'({elig, elig} >> ptr);
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) idx = SEL_W'(i);
        any = |elig;
        w   = ptr + idx;
    end
endmodule

// File: rtl/rr_mux8_arbiter.sv
// rr_mux8_arbiter: round-robin grant of eight 4-bit lanes into one valid/ready output register
module rr_mux8_arbiter
    import rr_mux8_arbiter_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        en_mask,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [SEL_W-1:0]          sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_src
);
    state_t             state, state_nxt;
    logic [SEL_W-1:0]   ptr, w;
    logic               any;
    logic [DATA_W-1:0]  lane;
    logic               grant;

    rr_pick8 u_pick (.elig(req & en_mask), .ptr(ptr), .any(any), .w(w));

    mux8by1 #(.W(DATA_W)) u_mux (.d(in_data), .op(w), .y(lane));

    assign grant = (state == STATE_IDLE) && any;

    always_comb begin
        state_nxt = state;
        if (grant)
            state_nxt = STATE_BUSY;
        else if (state == STATE_BUSY && out_valid && out_ready)
            state_nxt = STATE_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= STATE_IDLE;
        else        state <= state_nxt;

    // ack is a single-cycle pulse: cleared every cycle unless a grant is made
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ptr       <= '0;
            ack       <= '0;
            sel       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            ack <= '0;
            if (grant) begin
                out_data  <= lane;
                out_src   <= w;
                sel       <= w;
                ack       <= NUM_REQ'(1) << w;
                out_valid <= 1'b1;
                ptr       <= w + SEL_W'(1);
            end else if (state == STATE_BUSY && out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// tb_rr_mux8_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_rr_mux8_arbiter;
    logic        clk = 0, rst_n = 0;
    logic [7:0]  req = 0, en_mask = 8'hFF;
    logic [31:0] in_data = 0;
    logic        out_ready = 1;
    logic [7:0]  ack;
    logic [2:0]  sel, out_src;
    logic        out_valid;
    logic [3:0]  out_data;
    int total = 0, bad = 0;

    bit         m_busy;
    int         m_ptr;
    logic [7:0] m_ack;
    logic       m_valid;
    logic [3:0] m_data;
    logic [2:0] m_src;

    rr_mux8_arbiter #(.DATA_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .en_mask(en_mask), .in_data(in_data),
        .ack(ack), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src)
    );

    always #5 clk = ~clk;

    task automatic model_reset;
        m_busy = 0; m_ptr = 0; m_ack = 0; m_valid = 0; m_data = 0; m_src = 0;
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst_n = 0; req = 0; en_mask = 8'hFF; out_ready = 1;
        #3 rst_n = 1;
        model_reset();
    endtask

    // Advance one clock; the model applies the arbitration rules to the inputs seen before the edge
    task automatic cycle;
        logic [7:0] e;
        int win;
        e = req & en_mask;
        win = -1;
        m_ack = 0;
        if (!m_busy) begin
            for (int k = 0; k < 8; k++)
                if (win < 0 && e[(m_ptr + k) % 8]) win = (m_ptr + k) % 8;
            if (win >= 0) begin
                m_data  = in_data[4*win +: 4];
                m_src   = 3'(win);
                m_ack   = 8'(1) << win;
                m_valid = 1;
                m_ptr   = (win + 1) % 8;
                m_busy  = 1;
            end
        end else if (out_ready) begin
            m_valid = 0;
            m_busy  = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 0; #2;
        total++;
        if ({ack, sel, out_valid, out_data, out_src} !== 19'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {ack, sel, out_valid, out_data, out_src});
        end
        #1 rst_n = 1;
        model_reset();
    endtask

    task automatic test_single;
        do_reset();
        req = 8'h04; in_data = 0; in_data[11:8] = 4'hA; out_ready = 1;
        cycle();
        total++;
        if ({ack, out_valid, out_data, out_src, sel} !== {8'h04, 1'b1, 4'hA, 3'd2, 3'd2}) begin
            bad++; $display("FAIL single_capture got ack=%h v=%b d=%h src=%0d sel=%0d exp ack=04 v=1 d=a src=2 sel=2",
                            ack, out_valid, out_data, out_src, sel);
        end
        req = 0;
        cycle();
        total++;
        if ({out_valid, ack} !== 9'd0) begin
            bad++; $display("FAIL single_release got v=%b ack=%h exp v=0 ack=00", out_valid, ack);
        end
    endtask

    task automatic test_all_requesting;
        do_reset();
        for (int i = 0; i < 8; i++) in_data[4*i +: 4] = 4'(i);
        req = 8'hFF; out_ready = 1;
        for (int k = 0; k < 9; k++) begin
            cycle();
            total++;
            if (!out_valid || out_src !== 3'(k % 8) || out_data !== 4'(k % 8) || ack !== 8'(1) << (k % 8)) begin
                bad++; $display("FAIL rr_order k=%0d got v=%b src=%0d d=%h ack=%h exp src=%0d", k, out_valid, out_src, out_data, ack, k % 8);
            end
            cycle();
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL rr_gap k=%0d got v=%b exp 0", k, out_valid);
            end
        end
        req = 0;
    endtask

    task automatic test_backpressure;
        do_reset();
        req = 8'h08; in_data = 0; in_data[15:12] = 4'h5; out_ready = 0;
        cycle();
        total++;
        if (ack !== 8'h08 || !out_valid || out_data !== 4'h5) begin
            bad++; $display("FAIL bp_capture got ack=%h v=%b d=%h exp ack=08 v=1 d=5", ack, out_valid, out_data);
        end
        req = 8'h19; in_data[15:12] = 4'hF; en_mask = 8'hF7;
        for (int i = 0; i < 5; i++) begin
            cycle();
            total++;
            if (ack !== 0 || !out_valid || out_data !== 4'h5 || out_src !== 3'd3) begin
                bad++; $display("FAIL bp_hold i=%0d got ack=%h v=%b d=%h src=%0d exp ack=00 v=1 d=5 src=3", i, ack, out_valid, out_data, out_src);
            end
        end
        en_mask = 8'hFF; out_ready = 1;
        cycle();
        total++;
        if (out_valid !== 1'b0 || out_data !== 4'h5) begin
            bad++; $display("FAIL bp_release got v=%b d=%h exp v=0 d=5", out_valid, out_data);
        end
        cycle();
        total++;
        if (out_src !== 3'd4 || ack !== 8'h10) begin
            bad++; $display("FAIL bp_next_grant got src=%0d ack=%h exp src=4 ack=10", out_src, ack);
        end
        req = 0;
        cycle();
    endtask

    task automatic test_mask_wrap;
        do_reset();
        in_data = 32'h7654_3210; out_ready = 1;
        req = 8'h40;
        cycle(); cycle();
        req = 8'h81; en_mask = 8'h7F;
        cycle();
        total++;
        if (out_src !== 3'd0 || ack !== 8'h01) begin
            bad++; $display("FAIL wrap_masked got src=%0d ack=%h exp src=0 ack=01", out_src, ack);
        end
        cycle();
        en_mask = 8'hFF;
        cycle();
        total++;
        if (out_src !== 3'd7 || ack !== 8'h80 || out_data !== 4'h7) begin
            bad++; $display("FAIL wrap_unmasked got src=%0d ack=%h d=%h exp src=7 ack=80 d=7", out_src, ack, out_data);
        end
        req = 0;
        cycle();
    endtask

    task automatic test_async_reset;
        do_reset();
        in_data = 32'h7654_3219; req = 8'h02; out_ready = 0;
        cycle();
        #2 rst_n = 0;
        #1;
        total++;
        if (out_valid !== 0 || ack !== 0 || out_src !== 0 || out_data !== 0) begin
            bad++; $display("FAIL async_reset got v=%b ack=%h src=%0d d=%h exp all 0", out_valid, ack, out_src, out_data);
        end
        #1 rst_n = 1;
        model_reset();
        req = 8'h01; out_ready = 1;
        cycle();
        total++;
        if (out_src !== 3'd0 || ack !== 8'h01 || out_data !== 4'h9) begin
            bad++; $display("FAIL post_reset_grant got src=%0d ack=%h d=%h exp src=0 ack=01 d=9", out_src, ack, out_data);
        end
        req = 0;
        cycle();
    endtask

    task automatic test_random;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            req       = 8'($urandom);
            en_mask   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            total++;
            if ({ack, sel, out_valid, out_data, out_src} !== {m_ack, m_src, m_valid, m_data, m_src}) begin
                bad++; $display("FAIL random n=%0d got ack=%h sel=%0d v=%b d=%h src=%0d exp ack=%h sel=%0d v=%b d=%h src=%0d",
                                n, ack, sel, out_valid, out_data, out_src, m_ack, m_src, m_valid, m_data, m_src);
            end
        end
        req = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_requesting();
        test_backpressure();
        test_mask_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_mux8_arbiter.md
# rr_mux8_arbiter

Round-robin arbiter that shares one 8:1, 4-bit selection datapath between eight requesters. Each cycle it is idle, it grants one requester and drives the 3-bit select. It captures the chosen 4-bit word into an output register and presents it on a valid/ready output port. It sits between eight independent 4-bit producers and a single downstream consumer.

## Interface
Parameters:
- DATA_W, 4, width of each requester word; the select is fixed at 3 bits and the requester count at 8.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  8  level request; req[i] means in_data lane i holds valid data.
- en_mask  in  8  requester enable; req[i] is ignored while en_mask[i]=0.
- in_data  in  8*DATA_W  flat bus; lane i = in_data[DATA_W*i+DATA_W-1 : DATA_W*i].
- ack  out  8  one-hot, one-cycle registered pulse; the winner's word was captured.
- sel  out  3  registered select of the current or last grant; equal to out_src.
- out_valid  out  1  out_data/out_src valid.
- out_ready  in  1  consumer accepts when high together with out_valid.
- out_data  out  DATA_W  captured word.
- out_src  out  3  index of the requester that supplied out_data.

## Operation
- State register: IDLE, BUSY. Round-robin pointer ptr[2:0] holds the highest-priority index.
- Eligible vector: elig = req & en_mask.
- IDLE with elig != 0:
  - Winner w is the first set bit of elig scanning ptr, ptr+1, … modulo 8.
  - At the clock edge: out_data <= lane w, out_src <= w, sel <= w, ack[w] <= 1, out_valid <= 1, ptr <= (w+1) mod 8, state <= BUSY.
- IDLE with elig == 0: no change; ack = 0.
- BUSY:
  - Registers hold; ack returns to 0 after one cycle.
  - On out_valid & out_ready: out_valid <= 0, state <= IDLE. out_data, out_src and sel keep their last values.
- Requester rule: deassert req[i] in the cycle after ack[i], unless it presents a new word. A still-high req is treated as a new request.
- en_mask and req changes during BUSY do not affect the captured transfer.
- ptr wraps 7 -> 0. After w=7, priority order restarts at 0.
- No requester waits more than 7 other grants while it stays requesting and enabled.
- Reset (any time, including mid-transfer):
  - state=IDLE, ptr=0, out_valid=0, out_data=0, out_src=0, sel=0, ack=0.
  - Any pending word is dropped, and no ack is reissued.

## Timing
- Capture latency: elig nonzero in IDLE cycle N gives out_valid=1 and ack[w]=1 in cycle N+1.
- out_ready high in N+1 completes the handshake at the end of N+1. The state is IDLE in N+2, and the earliest next out_valid is N+3.
- Peak throughput is one word per 2 cycles.
- out_valid, once high, stays high with stable out_data/out_src until the handshake.
- out_ready low holds BUSY indefinitely; no new ack is issued meanwhile.
- All outputs are driven only from registers; there are no combinational paths from inputs to outputs.

## Structure
- Shared package: STATE_IDLE/STATE_BUSY encodings, NUM_REQ=8, SEL_W=3.
- One sub-module, rr_pick8:
  - Combinational.
  - Inputs: elig[7:0], ptr[2:0].
  - Outputs: any, w[2:0].
  - Implementation: rotate-and-priority-encode.
- Lane selection reuses the team's mux8by1 datapath, with op driven by the picker's w.

## Test plan
- Reset, single request: after reset, req=8'h04, lane2=4'hA, en_mask=8'hFF, out_ready=1. Expect ack=8'h04 and out_valid=1, out_data=4'hA, out_src=2 one cycle later; out_valid=0 the following cycle.
- All requesting: req=8'hFF held, lane i = i, out_ready=1. Expect out_src sequence 0,1,2,…,7,0, one word every 2 cycles.
- Backpressure: out_ready=0 for 5 cycles after capture. Expect out_valid and out_data stable, ack only in the capture cycle, ptr unchanged until release.
- Mask and wrap: ptr at 7, req=8'h81, en_mask=8'h7F. Expect grant to 0. Then set en_mask=8'hFF, which gives grant to 7 next.
- Async reset mid-BUSY: pull rst_n low while out_valid=1. Expect out_valid=0, ack=0, out_src=0 immediately. After release, req=8'h01 gives a grant to 0.
